// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: default word width and receiver state encoding.
package serial_pkg;

  localparam int unsigned SERIAL_WIDTH = 32;
  localparam int unsigned CNT_W        = $clog2(SERIAL_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_out_buffer.sv
// Single-entry Valid/Ready holding register with sticky overrun detection.
module rx_out_buffer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic accept_c;
  logic drop_c;

  // A slot frees up in the same cycle the consumer takes the current word.
  assign accept_c = load && (!valid || ready);
  assign drop_c   = load && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept_c) begin
        data  <= word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      overrun <= drop_c | (overrun & ~clear_err);
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Deserialises a strobed, frame-synced MSB-first bit stream into WIDTH-bit words.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit after each word (adds ParityErr).
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Din,
  input  logic             BitEn,
  input  logic             FrameSync,
  input  logic             RxReady,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] RxData,
  output logic             RxValid,
  output logic             RxBusy,
  output logic             FrameErr,
`ifdef SERIAL_RX_PARITY_EN
  output logic             ParityErr,
`endif
  output logic             Overrun
);

  localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1);
  localparam bit          ONE_BIT   = (WIDTH == 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned SH_W       = WIDTH;
  localparam bit          PAR_EN     = 1'b1;
  localparam rx_state_t   DONE_STATE = PARITY;
`else
  localparam int unsigned SH_W       = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam bit          PAR_EN     = 1'b0;
  localparam rx_state_t   DONE_STATE = IDLE;
`endif

  rx_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]      shreg_q, shreg_d;
  logic [WIDTH-1:0]     shifted_c;
  logic [WIDTH-1:0]     word_c;
  logic                 load_c;
  logic                 last_c;
  logic                 frame_err_set_c;
`ifdef SERIAL_RX_PARITY_EN
  logic                 parity_err_set_c;
`endif

  // Without parity only the low WIDTH-1 bits need storing; the incoming bit completes the word.
  if (ONE_BIT) begin : g_one
    assign shifted_c = Din;
  end else begin : g_multi
    assign shifted_c = {shreg_q[WIDTH-2:0], Din};
  end

  assign last_c = (cnt_q == CNT_WIDTH'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (BitEn && FrameSync) state_d = ONE_BIT ? DONE_STATE : SHIFT;
      SHIFT: if (BitEn && !FrameSync && last_c) state_d = DONE_STATE;
`ifdef SERIAL_RX_PARITY_EN
      PARITY: if (BitEn) state_d = FrameSync ? (ONE_BIT ? PARITY : SHIFT) : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d           = cnt_q;
    shreg_d         = shreg_q;
    word_c          = shifted_c;
    load_c          = 1'b0;
    frame_err_set_c = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_err_set_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (BitEn && FrameSync) begin
          shreg_d = SH_W'(shifted_c);
          cnt_d   = CNT_WIDTH'(ONE_BIT ? 0 : 1);
          load_c  = ONE_BIT && !PAR_EN;
        end
      end
      SHIFT: begin
        if (BitEn) begin
          shreg_d = SH_W'(shifted_c);
          if (FrameSync) begin
            frame_err_set_c = 1'b1;
            cnt_d           = CNT_WIDTH'(1);
          end else if (last_c) begin
            cnt_d  = '0;
            load_c = !PAR_EN;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      // Word sits in shreg_q until the parity bit arrives.
      PARITY: begin
        if (BitEn) begin
          if (FrameSync) begin
            frame_err_set_c = 1'b1;
            shreg_d         = SH_W'(shifted_c);
            cnt_d           = CNT_WIDTH'(ONE_BIT ? 0 : 1);
          end else begin
            load_c           = 1'b1;
            word_c           = WIDTH'(shreg_q);
            parity_err_set_c = ((^shreg_q) != Din);
            cnt_d            = '0;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath and flag registers; a set event outranks ClearErr.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      shreg_q  <= '0;
      RxBusy   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      RxBusy   <= (state_d == SHIFT);
      FrameErr <= frame_err_set_c | (FrameErr & ~ClearErr);
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ParityErr <= 1'b0;
    else        ParityErr <= parity_err_set_c | (ParityErr & ~ClearErr);
  end
`endif

  rx_out_buffer #(
    .WIDTH (WIDTH)
  ) u_out_buffer (
    .clk       (Clk),
    .rst_n     (Reset),
    .load      (load_c),
    .word      (word_c),
    .ready     (RxReady),
    .clear_err (ClearErr),
    .data      (RxData),
    .valid     (RxValid),
    .overrun   (Overrun)
  );

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: expected words queued by stimulus, checked by a monitor.
module tb_serial_receiver;

  localparam int unsigned W = 32;

  logic         Clk       = 1'b0;
  logic         Reset     = 1'b0;
  logic         Din       = 1'b0;
  logic         BitEn     = 1'b0;
  logic         FrameSync = 1'b0;
  logic         RxReady   = 1'b0;
  logic         ClearErr  = 1'b0;
  logic [W-1:0] RxData;
  logic         RxValid;
  logic         RxBusy;
  logic         FrameErr;
  logic         Overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic         ParityErr;
`endif

  serial_receiver #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Din       (Din),
    .BitEn     (BitEn),
    .FrameSync (FrameSync),
    .RxReady   (RxReady),
    .ClearErr  (ClearErr),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxBusy    (RxBusy),
    .FrameErr  (FrameErr),
`ifdef SERIAL_RX_PARITY_EN
    .ParityErr (ParityErr),
`endif
    .Overrun   (Overrun)
  );

  always #5 Clk = ~Clk;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic         busy_bad          = 1'b0;
  logic         valid_before_last = 1'b0;
  logic         prev_valid        = 1'b0;
  logic         prev_hs           = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Sends the top nbits of data MSB first, FrameSync on the first bit, gap idle cycles between bits.
  task automatic send_bits(input logic [W-1:0] data, input int nbits, input int gap, input bit rdy_last);
    busy_bad = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      BitEn     = 1'b1;
      FrameSync = (i == 0);
      Din       = data[W-1-i];
      if (i == nbits - 1) begin
        valid_before_last = RxValid;
        if (rdy_last) RxReady = 1'b1;
      end
      step();
      BitEn     = 1'b0;
      FrameSync = 1'b0;
      Din       = 1'b0;
      if (i < W - 1 && !RxBusy) busy_bad = 1'b1;
      if (i < nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          if (!RxBusy) busy_bad = 1'b1;
        end
      end
    end
  endtask

  // Monitor: a word is newly presented when RxValid rises or stays high right after a handshake.
  always @(negedge Clk) begin
    if (!Reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (RxValid && (!prev_valid || prev_hs)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL rxdata_unexpected: got %h, expected no word", RxData);
        end else begin
          chk("rxdata", RxData, exp_q.pop_front());
        end
      end
      prev_valid = RxValid;
      prev_hs    = RxValid && RxReady;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    chk("reset_rxdata",   RxData,   '0);
    chk("reset_rxvalid",  W'(RxValid),  '0);
    chk("reset_rxbusy",   W'(RxBusy),   '0);
    chk("reset_frameerr", W'(FrameErr), '0);
    chk("reset_overrun",  W'(Overrun),  '0);
    step();
    Reset   = 1'b1;
    RxReady = 1'b1;
    step();

    // Nominal word, strobe every cycle
    exp_q.push_back(32'hA5A50F0F);
    send_bits(32'hA5A50F0F, 32, 0, 1'b0);
    chk("nom_valid_before_last", W'(valid_before_last), '0);
    chk("nom_valid_latency",     W'(RxValid),  32'd1);
    chk("nom_busy_during_word",  W'(busy_bad), '0);
    chk("nom_busy_after",        W'(RxBusy),   '0);
    chk("nom_frameerr",          W'(FrameErr), '0);
    chk("nom_overrun",           W'(Overrun),  '0);
    repeat (2) step();

    // Same word, strobe every third cycle
    exp_q.push_back(32'hA5A50F0F);
    send_bits(32'hA5A50F0F, 32, 2, 1'b0);
    chk("gap_busy_through_gaps", W'(busy_bad), '0);
    chk("gap_valid",             W'(RxValid),  32'd1);
    repeat (2) step();

    // Resync after 10 bits
    send_bits(32'hFFC00000, 10, 0, 1'b0);
    chk("resync_no_err_yet", W'(FrameErr), '0);
    exp_q.push_back(32'h12345678);
    send_bits(32'h12345678, 32, 0, 1'b0);
    chk("resync_frameerr", W'(FrameErr), 32'd1);
    chk("resync_valid",    W'(RxValid),  32'd1);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    chk("resync_cleared", W'(FrameErr), '0);
    repeat (2) step();

    // Back-pressure and overrun
    RxReady = 1'b0;
    exp_q.push_back(32'h00000001);
    send_bits(32'h00000001, 32, 0, 1'b0);
    send_bits(32'h00000002, 32, 0, 1'b0);
    chk("ovr_overrun", W'(Overrun), 32'd1);
    chk("ovr_valid",   W'(RxValid), 32'd1);
    chk("ovr_rxdata",  RxData,      32'h00000001);
    RxReady = 1'b1;
    step();
    chk("ovr_drain_valid", W'(RxValid), '0);
    chk("ovr_sticky",      W'(Overrun), 32'd1);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    chk("ovr_cleared", W'(Overrun), '0);
    step();

    // Consume and complete in the same cycle
    RxReady = 1'b0;
    exp_q.push_back(32'h11111111);
    send_bits(32'h11111111, 32, 0, 1'b0);
    exp_q.push_back(32'h22222222);
    send_bits(32'h22222222, 32, 0, 1'b1);
    chk("simul_valid",   W'(RxValid), 32'd1);
    chk("simul_rxdata",  RxData,      32'h22222222);
    chk("simul_overrun", W'(Overrun), '0);
    step();
    chk("simul_consumed", W'(RxValid), '0);
    step();

    // Reset mid-word
    send_bits(32'hCAFEF00D, 16, 0, 1'b0);
    chk("rst_busy_before", W'(RxBusy), 32'd1);
    Reset = 1'b0;
    #2;
    chk("rst_rxdata",   RxData,       '0);
    chk("rst_rxvalid",  W'(RxValid),  '0);
    chk("rst_rxbusy",   W'(RxBusy),   '0);
    chk("rst_frameerr", W'(FrameErr), '0);
    chk("rst_overrun",  W'(Overrun),  '0);
    step();
    step();
    Reset = 1'b1;
    step();
    exp_q.push_back(32'hDEADBEEF);
    send_bits(32'hDEADBEEF, 32, 0, 1'b0);
    chk("post_rst_valid",    W'(RxValid),  32'd1);
    chk("post_rst_frameerr", W'(FrameErr), '0);
    repeat (3) step();

    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
